// File: rtl/spw_rx_spill_ctrl.sv
// -----------------------------------------------------------------------------
// spw_rx_spill_ctrl
//
// Receive-side packet spiller between the SpaceWire RX FIFO and the host/router
// data path. In normal operation characters pass straight through with zero
// latency. When spilling is enabled and a packet in flight breaks (link error,
// or upstream starvation for SPILL_TIMEOUT consecutive cycles), the packet is
// closed downstream with an EEP. The stale remainder upstream is then discarded
// up to and including its next EOP/EEP.
//
// Ports:
//   clk, reset          system clock, synchronous active-high reset
//   spill_enable        spill enable from the PIO register
//   link_error          single-cycle link error pulse
//   rx_valid/rx_data/rx_ready   upstream 9-bit character stream
//   tx_valid/tx_data/tx_ready   downstream 9-bit character stream
//   clear_counts        synchronous clear of the statistics counters
//   spill_active        high while terminating or discarding
//   spill_pkt_count     packets spilled (saturating)
//   spill_char_count    characters discarded (saturating)
// -----------------------------------------------------------------------------
module spw_rx_spill_ctrl #(
    parameter int SPILL_TIMEOUT = 1024,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             spill_enable,
    input  logic             link_error,
    input  logic             rx_valid,
    input  logic [8:0]       rx_data,
    output logic             rx_ready,
    output logic             tx_valid,
    output logic [8:0]       tx_data,
    input  logic             tx_ready,
    input  logic             clear_counts,
    output logic             spill_active,
    output logic [CNT_W-1:0] spill_pkt_count,
    output logic [CNT_W-1:0] spill_char_count
);

    localparam int STALL_W = $clog2(SPILL_TIMEOUT + 1);
    localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(SPILL_TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PKT,
        ST_TERM,
        ST_DROP
    } state_t;

    state_t             state_reg, state_next;
    logic [STALL_W-1:0] stall_cnt_reg, stall_cnt_next;

    logic       is_end;
    logic       xfer;
    logic       trigger;
    logic [1:0] cnt_inc;
    logic [2*CNT_W-1:0] cnt_flat;

    // Only control codes 0x100 (EOP) and 0x101 (EEP) end a packet; other
    // control codes travel like data.
    assign is_end  = rx_data[8] && (rx_data[7:1] == 7'd0);
    assign xfer    = rx_valid && rx_ready;
    assign trigger = spill_enable && (link_error || (stall_cnt_reg == STALL_MAX));

    // Datapath muxing: pass-through unless terminating or discarding.
    always_comb begin
        tx_valid = rx_valid;
        tx_data  = rx_data;
        rx_ready = tx_ready;
        case (state_reg)
            ST_TERM: begin
                tx_valid = 1'b1;
                tx_data  = 9'h101;
                rx_ready = 1'b0;
            end
            ST_DROP: begin
                tx_valid = 1'b0;
                rx_ready = 1'b1;
            end
            default: ;
        endcase
    end

    // Next-state logic. In PKT an end-marker transfer wins over a same-cycle
    // trigger; a data transfer on the trigger cycle still goes through.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (xfer && !is_end) state_next = ST_PKT;
            ST_PKT: begin
                if (xfer && is_end) state_next = ST_IDLE;
                else if (trigger)   state_next = ST_TERM;
            end
            ST_TERM: if (tx_ready)        state_next = ST_DROP;
            ST_DROP: if (xfer && is_end)  state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Starvation counter only runs mid-packet; it saturates so that a late
    // rising spill_enable still sees the timeout condition.
    always_comb begin
        stall_cnt_next = '0;
        if (state_reg == ST_PKT && !rx_valid) begin
            stall_cnt_next = (stall_cnt_reg == STALL_MAX) ? STALL_MAX
                                                          : stall_cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            stall_cnt_reg <= '0;
        end else begin
            state_reg     <= state_next;
            stall_cnt_reg <= stall_cnt_next;
        end
    end

    // Index 0: spilled packets, index 1: discarded characters.
    assign cnt_inc[0] = (state_reg == ST_DROP) && xfer && is_end;
    assign cnt_inc[1] = (state_reg == ST_DROP) && xfer;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
            logic [CNT_W-1:0] cnt_reg;
            // Clear beats a coincident increment.
            always_ff @(posedge clk) begin
                if (reset || clear_counts) begin
                    cnt_reg <= '0;
                end else if (cnt_inc[gi] && (cnt_reg != {CNT_W{1'b1}})) begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end
            assign cnt_flat[gi*CNT_W +: CNT_W] = cnt_reg;
        end
    endgenerate

    assign spill_pkt_count  = cnt_flat[0 +: CNT_W];
    assign spill_char_count = cnt_flat[CNT_W +: CNT_W];
    assign spill_active     = (state_reg == ST_TERM) || (state_reg == ST_DROP);

endmodule

// File: tb/tb_spw_rx_spill_ctrl.sv
// -----------------------------------------------------------------------------
// tb_spw_rx_spill_ctrl
//
// Self-checking bench for spw_rx_spill_ctrl with SPILL_TIMEOUT=4, CNT_W=2.
// A table of vectors with hand-written expectations, directed corner-case
// sequences, then randomized traffic against a behavioural reference model.
// -----------------------------------------------------------------------------
module tb_spw_rx_spill_ctrl;

    localparam int T   = 4;
    localparam int CW  = 2;
    localparam int SAT = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset, spill_enable, link_error, rx_valid, tx_ready, clear_counts;
    logic [8:0]    rx_data;
    logic          rx_ready, tx_valid, spill_active;
    logic [8:0]    tx_data;
    logic [CW-1:0] spill_pkt_count, spill_char_count;

    int n_cmp = 0;
    int n_bad = 0;

    spw_rx_spill_ctrl #(.SPILL_TIMEOUT(T), .CNT_W(CW)) dut (
        .clk              (clk),
        .reset            (reset),
        .spill_enable     (spill_enable),
        .link_error       (link_error),
        .rx_valid         (rx_valid),
        .rx_data          (rx_data),
        .rx_ready         (rx_ready),
        .tx_valid         (tx_valid),
        .tx_data          (tx_data),
        .tx_ready         (tx_ready),
        .clear_counts     (clear_counts),
        .spill_active     (spill_active),
        .spill_pkt_count  (spill_pkt_count),
        .spill_char_count (spill_char_count)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model: a packet is "open" after a non-end character has
    // gone downstream; a broken packet first owes an EEP downstream, then
    // swallows upstream input until an end marker.
    // ------------------------------------------------------------------
    bit m_open, m_owe_eep, m_swallow;
    int m_starved, m_pkts, m_chars;

    function automatic bit end_mark(input logic [8:0] d);
        return (d == 9'h100) || (d == 9'h101);
    endfunction

    function automatic bit m_rx_ready();
        if (m_owe_eep) return 1'b0;
        if (m_swallow) return 1'b1;
        return tx_ready;
    endfunction

    function automatic bit m_tx_valid();
        if (m_owe_eep) return 1'b1;
        if (m_swallow) return 1'b0;
        return rx_valid;
    endfunction

    function automatic logic [8:0] m_tx_data();
        return m_owe_eep ? 9'h101 : rx_data;
    endfunction

    task automatic model_edge();
        bit acc, em, starved_now;
        acc = rx_valid && m_rx_ready();
        em  = end_mark(rx_data);
        starved_now = m_open && !rx_valid;
        if (reset) begin
            m_open = 0; m_owe_eep = 0; m_swallow = 0;
            m_starved = 0; m_pkts = 0; m_chars = 0;
            return;
        end
        if (m_swallow && acc) begin
            m_chars = (m_chars < SAT) ? m_chars + 1 : SAT;
            if (em) m_pkts = (m_pkts < SAT) ? m_pkts + 1 : SAT;
        end
        if (clear_counts) begin
            m_pkts = 0; m_chars = 0;
        end
        if (m_owe_eep) begin
            if (tx_ready) begin m_owe_eep = 0; m_swallow = 1; end
        end else if (m_swallow) begin
            if (acc && em) m_swallow = 0;
        end else if (m_open) begin
            if (acc && em) m_open = 0;
            else if (spill_enable && (link_error || m_starved >= T)) begin
                m_open = 0; m_owe_eep = 1;
            end
        end else if (acc && !em) begin
            m_open = 1;
        end
        // Number of consecutive starved mid-packet cycles, capped at T.
        m_starved = starved_now ? ((m_starved < T) ? m_starved + 1 : T) : 0;
        if (!m_open) m_starved = 0;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input bit rst, en, lerr, rv, input logic [8:0] rd,
                         input bit trdy, clr);
        reset = rst; spill_enable = en; link_error = lerr; rx_valid = rv;
        rx_data = rd; tx_ready = trdy; clear_counts = clr;
    endtask

    // Settle to the negative edge and compare against the model.
    task automatic settle_and_model_check(input bit do_chk);
        @(negedge clk);
        if (do_chk) begin
            chk("m_tx_valid", int'(tx_valid), int'(m_tx_valid()));
            if (m_tx_valid()) chk("m_tx_data", int'(tx_data), int'(m_tx_data()));
            chk("m_rx_ready", int'(rx_ready), int'(m_rx_ready()));
            chk("m_active", int'(spill_active), int'(m_owe_eep || m_swallow));
            chk("m_pkt_cnt", int'(spill_pkt_count), m_pkts);
            chk("m_char_cnt", int'(spill_char_count), m_chars);
        end
    endtask

    task automatic finish_cycle();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic cycle(input bit rst, en, lerr, rv, input logic [8:0] rd,
                         input bit trdy, clr);
        drive(rst, en, lerr, rv, rd, trdy, clr);
        settle_and_model_check(1'b1);
        finish_cycle();
    endtask

    bit cur_en = 1'b1;
    task automatic send(input logic [8:0] rd);
        cycle(0, cur_en, 0, 1, rd, 1, 0);
    endtask
    task automatic starve(input bit lerr);
        cycle(0, cur_en, lerr, 0, 9'h000, 1, 0);
    endtask
    task automatic clear();
        cycle(0, cur_en, 0, 0, 9'h000, 1, 1);
    endtask

    // ------------------------------------------------------------------
    typedef struct {
        bit rst, en, lerr, rv;
        logic [8:0] rd;
        bit trdy, clr;
        bit etv;
        logic [8:0] etd;
        bit err, eact;
        int epc, ecc;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(bit rst, bit en, bit lerr, bit rv, logic [8:0] rd,
                                bit trdy, bit etv, logic [8:0] etd, bit err,
                                bit eact, int epc, int ecc);
        vec_t v;
        v.rst = rst; v.en = en; v.lerr = lerr; v.rv = rv; v.rd = rd;
        v.trdy = trdy; v.clr = 0; v.etv = etv; v.etd = etd; v.err = err;
        v.eact = eact; v.epc = epc; v.ecc = ecc;
        return v;
    endfunction

    initial begin
        drive(1, 1, 0, 0, 9'h000, 1, 0);
        settle_and_model_check(1'b0);
        finish_cycle();

        // rst en lerr rv  rd     trdy | tv  td     rr act pc cc
        vt.push_back(mk(0, 1, 0, 0, 9'h000, 1, 0, 9'h000, 1, 0, 0, 0)); // reset state
        vt.push_back(mk(0, 1, 0, 1, 9'h041, 1, 1, 9'h041, 1, 0, 0, 0)); // pass-through
        vt.push_back(mk(0, 1, 0, 1, 9'h042, 1, 1, 9'h042, 1, 0, 0, 0));
        vt.push_back(mk(0, 1, 0, 1, 9'h100, 1, 1, 9'h100, 1, 0, 0, 0));
        vt.push_back(mk(0, 1, 0, 1, 9'h050, 0, 1, 9'h050, 0, 0, 0, 0)); // backpressure follows
        vt.push_back(mk(0, 1, 0, 1, 9'h011, 1, 1, 9'h011, 1, 0, 0, 0)); // link-error spill
        vt.push_back(mk(0, 1, 0, 1, 9'h012, 1, 1, 9'h012, 1, 0, 0, 0));
        vt.push_back(mk(0, 1, 1, 0, 9'h000, 1, 0, 9'h000, 1, 0, 0, 0));
        vt.push_back(mk(0, 1, 0, 1, 9'h013, 1, 1, 9'h101, 0, 1, 0, 0)); // TERM
        vt.push_back(mk(0, 1, 0, 1, 9'h013, 1, 0, 9'h000, 1, 1, 0, 0)); // DROP
        vt.push_back(mk(0, 1, 0, 1, 9'h014, 1, 0, 9'h000, 1, 1, 0, 1));
        vt.push_back(mk(0, 1, 0, 1, 9'h100, 1, 0, 9'h000, 1, 1, 0, 2));
        vt.push_back(mk(0, 1, 0, 0, 9'h000, 1, 0, 9'h000, 1, 0, 1, 3)); // back in IDLE

        for (int i = 0; i < vt.size(); i++) begin
            drive(vt[i].rst, vt[i].en, vt[i].lerr, vt[i].rv, vt[i].rd, vt[i].trdy, vt[i].clr);
            settle_and_model_check(1'b1);
            chk($sformatf("vec%0d_tx_valid", i), int'(tx_valid), int'(vt[i].etv));
            if (vt[i].etv) chk($sformatf("vec%0d_tx_data", i), int'(tx_data), int'(vt[i].etd));
            chk($sformatf("vec%0d_rx_ready", i), int'(rx_ready), int'(vt[i].err));
            chk($sformatf("vec%0d_active", i), int'(spill_active), int'(vt[i].eact));
            chk($sformatf("vec%0d_pkt_cnt", i), int'(spill_pkt_count), vt[i].epc);
            chk($sformatf("vec%0d_char_cnt", i), int'(spill_char_count), vt[i].ecc);
            finish_cycle();
        end

        // Starvation timeout: stall_cnt reaches T after 4 starved cycles,
        // the trigger is seen on the 5th, TERM follows.
        clear();
        send(9'h021);
        for (int i = 0; i < T; i++) starve(0);
        chk("to_not_yet", int'(spill_active), 0);
        starve(0);
        chk("to_term", int'(spill_active), 1);
        chk("to_eep_valid", int'(tx_valid), 1);
        chk("to_eep_data", int'(tx_data), 9'h101);
        starve(0);
        send(9'h022);
        send(9'h101);
        chk("to_pkts", int'(spill_pkt_count), 1);
        chk("to_chars", int'(spill_char_count), 2);
        chk("to_idle", int'(spill_active), 0);

        // Spill disabled: neither error nor starvation spills.
        clear();
        cur_en = 0;
        send(9'h031);
        starve(1);
        for (int i = 0; i < 10; i++) starve(0);
        chk("dis_no_spill", int'(spill_active), 0);
        send(9'h032);
        send(9'h100);
        chk("dis_pkts", int'(spill_pkt_count), 0);
        chk("dis_chars", int'(spill_char_count), 0);
        // Saturated stall counter + rising enable triggers immediately.
        send(9'h033);
        for (int i = 0; i < 6; i++) starve(0);
        cur_en = 1;
        starve(0);
        chk("rise_en_term", int'(spill_active), 1);
        starve(0);
        send(9'h100);

        // TERM backpressure.
        clear();
        send(9'h041);
        starve(1);
        for (int i = 0; i < 5; i++) begin
            cycle(0, 1, 0, 1, 9'h042, 0, 0);
            chk("bp_tv", int'(tx_valid), 1);
            chk("bp_td", int'(tx_data), 9'h101);
            chk("bp_rr", int'(rx_ready), 0);
        end
        cycle(0, 1, 0, 1, 9'h042, 1, 0);
        chk("bp_drop_tv", int'(tx_valid), 0);
        chk("bp_drop_rr", int'(rx_ready), 1);
        send(9'h100);

        // EOP on the same cycle as link_error: no spill.
        send(9'h051);
        cycle(0, 1, 1, 1, 9'h100, 1, 0);
        chk("eop_err_idle", int'(spill_active), 0);
        send(9'h052);
        send(9'h100);

        // Saturation of both counters over 5 spilled packets.
        clear();
        for (int i = 0; i < 5; i++) begin
            send(9'h061);
            starve(1);
            starve(0);
            send(9'h100);
        end
        chk("sat_pkts", int'(spill_pkt_count), SAT);
        chk("sat_chars", int'(spill_char_count), SAT);

        // Clear coinciding with an increment.
        send(9'h071);
        starve(1);
        starve(0);
        cycle(0, 1, 0, 1, 9'h100, 1, 1);
        chk("clr_pkts", int'(spill_pkt_count), 0);
        chk("clr_chars", int'(spill_char_count), 0);

        // Reset while discarding, then pass-through of the next character.
        send(9'h081);
        starve(1);
        starve(0);
        cycle(1, 1, 0, 1, 9'h082, 1, 0);
        chk("rst_drop_idle", int'(spill_active), 0);
        drive(0, 1, 0, 1, 9'h055, 1, 0);
        #2;
        chk("rst_pass_tv", int'(tx_valid), 1);
        chk("rst_pass_td", int'(tx_data), 9'h055);
        chk("rst_pass_rr", int'(rx_ready), 1);
        send(9'h055);
        send(9'h100);

        // Randomized traffic against the model.
        begin
            int hold = 0;
            for (int i = 0; i < 3000; i++) begin
                bit rv;
                logic [8:0] rd;
                if (hold > 0) begin
                    rv = 0; hold--;
                end else begin
                    rv = ($urandom % 4) != 0;
                    if ($urandom % 32 == 0) hold = $urandom_range(3, 8);
                end
                case ($urandom % 8)
                    0: rd = 9'h100;
                    1: rd = 9'h101;
                    default: rd = 9'($urandom % 512);
                endcase
                cycle(($urandom % 300) == 0, ($urandom % 8) != 0,
                      ($urandom % 16) == 0, rv, rd,
                      ($urandom % 4) != 0, ($urandom % 64) == 0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
